decode: RTL

DECODE -- requirements
Module: decode

---
 rtl/decode.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode.sv
// RV32I(+M) decode stage: combinational register-file read addresses plus a
// registered, stallable decode of the fetched instruction.
module decode #(
  parameter int unsigned ENABLE_MUL = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] next_pc_in,
  input  logic [31:0] instruction_in,
  input  logic        valid_in,
  input  logic        stall,
  input  logic        invalidate,
  output logic [4:0]  rs1_address,
  output logic [4:0]  rs2_address,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [4:0]  rs1_address_out,
  output logic [4:0]  rs2_address_out,
  output logic [4:0]  rd_address_out,
  output logic [31:0] imm_out,
  output logic [2:0]  funct3_out,
  output logic [15:0] ctrl_out,
  output logic        valid_out
);

  typedef enum logic [4:0] {
    OPC_LOAD     = 5'b00000,
    OPC_MISC_MEM = 5'b00011,
    OPC_OP_IMM   = 5'b00100,
    OPC_AUIPC    = 5'b00101,
    OPC_STORE    = 5'b01000,
    OPC_OP       = 5'b01100,
    OPC_LUI      = 5'b01101,
    OPC_BRANCH   = 5'b11000,
    OPC_JALR     = 5'b11001,
    OPC_JAL      = 5'b11011,
    OPC_SYSTEM   = 5'b11100
  } opcode_e;

  // instruction[31:7] of the privileged funct3=0 SYSTEM encodings
  typedef enum logic [24:0] {
    SYS_ECALL  = 25'h0000000,
    SYS_EBREAK = 25'h0002000,
    SYS_MRET   = 25'h0604000,
    SYS_WFI    = 25'h020A000
  } sys_e;

  typedef struct packed {
    logic illegal;
    logic mret;
    logic ebreak;
    logic ecall;
    logic mul;
    logic csr;
    logic store;
    logic load;
    logic jalr;
    logic jal;
    logic branch;
    logic src_b_imm;
    logic src_a_zero;
    logic src_a_pc;
    logic alu_alt;
    logic rd_write;
  } ctrl_t;

  opcode_e     opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_field;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;

  ctrl_t       dec_ctrl;
  logic [31:0] dec_imm;
  logic [2:0]  dec_funct3;
  logic        use_rs1, use_rs2, use_rd, ill;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        load_new;

  assign rs1_address = instruction_in[19:15];
  assign rs2_address = instruction_in[24:20];

  assign opcode   = opcode_e'(instruction_in[6:2]);
  assign funct3   = instruction_in[14:12];
  assign funct7   = instruction_in[31:25];
  assign rd_field = instruction_in[11:7];

  assign imm_i = {{20{instruction_in[31]}}, instruction_in[31:20]};
  assign imm_s = {{20{instruction_in[31]}}, instruction_in[31:25], instruction_in[11:7]};
  assign imm_b = {{19{instruction_in[31]}}, instruction_in[31], instruction_in[7],
                  instruction_in[30:25], instruction_in[11:8], 1'b0};
  assign imm_u = {instruction_in[31:12], 12'b0};
  assign imm_j = {{11{instruction_in[31]}}, instruction_in[31], instruction_in[19:12],
                  instruction_in[20], instruction_in[30:21], 1'b0};
  assign imm_z = {20'b0, instruction_in[31:20]};

  always_comb begin
    dec_ctrl   = '0;
    dec_imm    = '0;
    dec_funct3 = funct3;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    use_rd     = 1'b0;
    ill        = 1'b0;

    if (instruction_in[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (opcode)
        OPC_LUI: begin
          dec_ctrl.src_a_zero = 1'b1;
          dec_ctrl.src_b_imm  = 1'b1;
          dec_imm    = imm_u;
          dec_funct3 = '0;
          use_rd     = 1'b1;
        end
        OPC_AUIPC: begin
          dec_ctrl.src_a_pc  = 1'b1;
          dec_ctrl.src_b_imm = 1'b1;
          dec_imm    = imm_u;
          dec_funct3 = '0;
          use_rd     = 1'b1;
        end
        OPC_JAL: begin
          dec_ctrl.jal       = 1'b1;
          dec_ctrl.src_a_pc  = 1'b1;
          dec_ctrl.src_b_imm = 1'b1;
          dec_imm    = imm_j;
          dec_funct3 = '0;
          use_rd     = 1'b1;
        end
        OPC_JALR: begin
          dec_ctrl.jalr      = 1'b1;
          dec_ctrl.src_b_imm = 1'b1;
          dec_imm = imm_i;
          use_rs1 = 1'b1;
          use_rd  = 1'b1;
          ill     = (funct3 != 3'd0);
        end
        OPC_BRANCH: begin
          dec_ctrl.branch    = 1'b1;
          dec_ctrl.src_a_pc  = 1'b1;
          dec_ctrl.src_b_imm = 1'b1;
          dec_imm = imm_b;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          ill     = (funct3[2:1] == 2'b01);
        end
        OPC_LOAD: begin
          dec_ctrl.load      = 1'b1;
          dec_ctrl.src_b_imm = 1'b1;
          dec_imm = imm_i;
          use_rs1 = 1'b1;
          use_rd  = 1'b1;
          ill     = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
        end
        OPC_STORE: begin
          dec_ctrl.store     = 1'b1;
          dec_ctrl.src_b_imm = 1'b1;
          dec_imm = imm_s;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          ill     = (funct3 > 3'd2);
        end
        OPC_OP_IMM: begin
          dec_ctrl.src_b_imm = 1'b1;
          dec_ctrl.alu_alt   = (funct3 == 3'd5) && instruction_in[30];
          dec_imm = imm_i;
          use_rs1 = 1'b1;
          use_rd  = 1'b1;
          if (funct3 == 3'd1)
            ill = (funct7 != 7'h00);
          else if (funct3 == 3'd5)
            ill = (funct7 != 7'h00) && (funct7 != 7'h20);
        end
        OPC_OP: begin
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          use_rd  = 1'b1;
          case (funct7)
            7'h00: ;
            7'h20: begin
              if ((funct3 == 3'd0) || (funct3 == 3'd5))
                dec_ctrl.alu_alt = 1'b1;
              else
                ill = 1'b1;
            end
            7'h01: begin
              if (ENABLE_MUL != 0)
                dec_ctrl.mul = 1'b1;
              else
                ill = 1'b1;
            end
            default: ill = 1'b1;
          endcase
        end
        OPC_MISC_MEM: ;
        OPC_SYSTEM: begin
          if (funct3 == 3'd0) begin
            case (instruction_in[31:7])
              SYS_ECALL:  dec_ctrl.ecall  = 1'b1;
              SYS_EBREAK: dec_ctrl.ebreak = 1'b1;
              SYS_MRET:   dec_ctrl.mret   = 1'b1;
              SYS_WFI:    ;
              default:    ill = 1'b1;
            endcase
          end else if (funct3 == 3'd4) begin
            ill = 1'b1;
          end else begin
            dec_ctrl.csr = 1'b1;
            dec_imm = imm_z;
            use_rs1 = ~funct3[2];
            use_rd  = 1'b1;
          end
        end
        default: ill = 1'b1;
      endcase
    end

    // An illegal word collapses to the single illegal flag and no operands.
    if (ill) begin
      dec_ctrl         = '0;
      dec_ctrl.illegal = 1'b1;
      use_rs1          = 1'b0;
      use_rs2          = 1'b0;
      use_rd           = 1'b0;
    end
    dec_ctrl.rd_write = use_rd && (rd_field != 5'd0);
  end

  assign dec_rs1  = use_rs1 ? instruction_in[19:15] : '0;
  assign dec_rs2  = use_rs2 ? instruction_in[24:20] : '0;
  assign dec_rd   = dec_ctrl.rd_write ? rd_field : '0;
  assign load_new = valid_in && !invalidate;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_out          <= '0;
      next_pc_out     <= '0;
      rs1_address_out <= '0;
      rs2_address_out <= '0;
      rd_address_out  <= '0;
      imm_out         <= '0;
      funct3_out      <= '0;
      ctrl_out        <= '0;
      valid_out       <= 1'b0;
    end else if (!stall) begin
      pc_out          <= pc_in;
      next_pc_out     <= next_pc_in;
      rs1_address_out <= dec_rs1;
      rs2_address_out <= dec_rs2;
      rd_address_out  <= dec_rd;
      imm_out         <= dec_imm;
      funct3_out      <= dec_funct3;
      ctrl_out        <= load_new ? 16'(dec_ctrl) : '0;
      valid_out       <= load_new;
    end
  end

endmodule
